fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: stall/redirect control from decode, imem request/response,
// and the registered instruction handed to decode.
interface fetch_stage_if;
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_redirect_pc_32;
  logic [31:0] w_imem_addr_32;
  logic        w_imem_rd;
  logic [31:0] w_imem_data_32;
  logic [31:0] w_instr_out_32;
  logic [31:0] w_pc_out_32;
  logic        w_valid;

  modport master (
    input  w_stall, w_redirect, w_redirect_pc_32, w_imem_data_32,
    output w_imem_addr_32, w_imem_rd, w_instr_out_32, w_pc_out_32, w_valid
  );

  modport slave (
    output w_stall, w_redirect, w_redirect_pc_32, w_imem_data_32,
    input  w_imem_addr_32, w_imem_rd, w_instr_out_32, w_pc_out_32, w_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: 2-cycle issue-to-output, one instr/cycle; redirect wins over stall.
// Stall freezes outputs and parks the in-flight word in a one-entry skid.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h80020000
) (
  input  logic           clock,
  input  logic           reset,
  fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_issue;
  logic [31:0] w_target;

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_tag;
  logic        r_skid_full;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_out_valid;

  assign w_target = bus.w_redirect_pc_32 & 32'hFFFF_FFFC;

  // A parked skid word must drain to the output before a new request goes out.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    if (bus.w_redirect) begin
      w_state_nxt = SQUASH;
    end else if (bus.w_stall) begin
      w_state_nxt = HOLD;
    end else begin
      w_state_nxt = FETCH;
      case (r_state)
        FETCH, SQUASH: w_issue = 1'b1;
        HOLD:          w_issue = !r_skid_full;
        default:       w_issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= PC_RESET;
      r_inflight   <= 1'b0;
      r_tag        <= '0;
      r_skid_full  <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_out_instr  <= '0;
      r_out_pc     <= '0;
      r_out_valid  <= 1'b0;
    end else if (bus.w_redirect) begin
      r_pc        <= w_target;
      r_inflight  <= 1'b0;
      r_skid_full <= 1'b0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.w_stall) begin
      if (r_inflight) begin
        r_skid_instr <= bus.w_imem_data_32;
        r_skid_pc    <= r_tag;
        r_skid_full  <= 1'b1;
      end
      r_inflight <= 1'b0;
    end else begin
      if (r_skid_full) begin
        r_out_instr <= r_skid_instr;
        r_out_pc    <= r_skid_pc;
        r_out_valid <= 1'b1;
        r_skid_full <= 1'b0;
      end else if (r_inflight) begin
        r_out_instr <= bus.w_imem_data_32;
        r_out_pc    <= r_tag;
        r_out_valid <= 1'b1;
      end else begin
        r_out_instr <= '0;
        r_out_valid <= 1'b0;
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        r_pc  <= r_pc + 32'd4;
      end
    end
  end

  assign bus.w_imem_addr_32 = r_pc;
  assign bus.w_imem_rd      = w_issue & ~reset;
  assign bus.w_instr_out_32 = r_out_instr;
  assign bus.w_pc_out_32    = r_out_pc;
  assign bus.w_valid        = r_out_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset traffic,
// compared each cycle against a queue-based model of fetched-but-undelivered words.
module tb_fetch_stage;

  localparam logic [31:0] PC_RESET = 32'h80020000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          age;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if bus ();

  fetch_stage #(.PC_RESET(PC_RESET)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        prev_rd   = 1'b0;
  logic [31:0] prev_addr = '0;

  logic [31:0] m_pc = PC_RESET;
  logic [31:0] m_out_instr = '0;
  logic [31:0] m_out_pc = '0;
  logic        m_out_valid = 1'b0;
  ent_t        m_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == PC_RESET) return 32'h24020005;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst_i, input bit stall_i, input bit redir_i,
                      input logic [31:0] tgt_i);
    bit   waiting;
    bit   exp_rd;
    ent_t e;
    @(negedge clk);
    rst                  = rst_i;
    bus.w_stall          = stall_i;
    bus.w_redirect       = redir_i;
    bus.w_redirect_pc_32 = tgt_i;
    bus.w_imem_data_32   = prev_rd ? mem_word(prev_addr) : $urandom;

    // A word that already arrived but is still undelivered blocks new requests.
    waiting = 1'b0;
    for (int i = 0; i < m_q.size(); i++)
      if (m_q[i].age >= 1) waiting = 1'b1;
    exp_rd = !rst_i && !stall_i && !redir_i && !waiting;

    #1;
    chk("imem_rd", {31'b0, bus.w_imem_rd}, {31'b0, exp_rd});
    if (!rst_i) chk("imem_addr", bus.w_imem_addr_32, m_pc);
    prev_rd   = bus.w_imem_rd;
    prev_addr = bus.w_imem_addr_32;

    if (rst_i) begin
      m_q.delete();
      m_pc        = PC_RESET;
      m_out_instr = '0;
      m_out_pc    = '0;
      m_out_valid = 1'b0;
    end else if (redir_i) begin
      m_q.delete();
      m_pc        = tgt_i & 32'hFFFF_FFFC;
      m_out_instr = '0;
      m_out_valid = 1'b0;
    end else if (stall_i) begin
      for (int i = 0; i < m_q.size(); i++) begin
        e = m_q[i];
        e.age = e.age + 1;
        m_q[i] = e;
      end
    end else begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_out_instr = e.data;
        m_out_pc    = e.pc;
        m_out_valid = 1'b1;
      end else begin
        m_out_instr = '0;
        m_out_valid = 1'b0;
      end
      if (exp_rd) begin
        e.pc   = m_pc;
        e.data = mem_word(m_pc);
        e.age  = 0;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    chk("instr_out", bus.w_instr_out_32, m_out_instr);
    chk("pc_out", bus.w_pc_out_32, m_out_pc);
    chk("valid", {31'b0, bus.w_valid}, {31'b0, m_out_valid});
  endtask

  initial begin
    bit          r_b, s_b, d_b;
    logic [31:0] tgt;

    bus.w_stall          = 1'b0;
    bus.w_redirect       = 1'b0;
    bus.w_redirect_pc_32 = '0;
    bus.w_imem_data_32   = '0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_valid", {31'b0, bus.w_valid}, 32'd0);
    chk("rst_pc", bus.w_pc_out_32, 32'h0);

    // Start-up stream from PC_RESET
    step(0, 0, 0, 0);
    chk("first_addr", prev_addr, 32'h80020000);
    step(0, 0, 0, 0);
    chk("first_instr", bus.w_instr_out_32, 32'h24020005);
    chk("first_pc", bus.w_pc_out_32, 32'h80020000);
    step(0, 0, 0, 0);
    chk("second_pc", bus.w_pc_out_32, 32'h80020004);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_stall_addr", prev_addr, 32'h80020010);

    // Stall with 0x80020010 in flight
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stall_rd", {31'b0, prev_rd}, 32'd0);
    step(0, 0, 0, 0);
    chk("skid_pc", bus.w_pc_out_32, 32'h80020010);
    chk("skid_valid", {31'b0, bus.w_valid}, 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("after_skid_pc", bus.w_pc_out_32, 32'h80020014);

    // Redirect while stalled
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h80020103);
    chk("redir_bubble", {31'b0, bus.w_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("redir_addr", prev_addr, 32'h80020100);
    step(0, 0, 0, 0);
    chk("redir_pc", bus.w_pc_out_32, 32'h80020100);

    // Wrap at the top of the address space
    step(0, 0, 1, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_pc_hi", bus.w_pc_out_32, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc_lo", bus.w_pc_out_32, 32'h00000000);

    // Back-to-back redirects: latest target wins
    step(0, 0, 1, 32'h80030000);
    step(0, 0, 1, 32'h80040008);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("redir2_pc", bus.w_pc_out_32, 32'h80040008);

    // Reset with skid full and redirect asserted
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h12345678);
    chk("rst_ovr_valid", {31'b0, bus.w_valid}, 32'd0);
    chk("rst_ovr_instr", bus.w_instr_out_32, 32'h0);
    chk("rst_ovr_pc", bus.w_pc_out_32, 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      r_b = ($urandom_range(0, 99) < 2);
      s_b = ($urandom_range(0, 3) == 0);
      d_b = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r_b, s_b, d_b, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
